spi_mem_responder: RTL and testbench
====================================

Name: spi_mem_responder

Overview:
- SPI mode-0 target that answers the 0x03 READ / 0x02 WRITE command set with a 24-bit address, as issued by the system SPI flash/PSRAM controller.
- Serves as an on-chip memory target, a debug/load port, and a bench responder for the controller.
- Oversamples SCLK/CS/MOSI in its own clock domain.
- Translates serial transactions into single-cycle accesses on a simple synchronous byte memory port.

Parameters:
SYNC_STAGES, 2, synchroniser depth for sclk/cs/mosi inputs (min 2)
ADDR_WIDTH, 16, memory address width; address bits above ADDR_WIDTH-1 are received and ignored

Ports:
clk_in  input  1  system clock; must be >= 4x SCLK frequency
reset_n_in  input  1  asynchronous active-low reset
sclk_in  input  1  SPI clock from controller (idle low)
cs_n_in  input  1  chip select, active low
mosi_in  input  1  controller-to-target data, MSB first
miso_out  output  1  target-to-controller data, MSB first
miso_oe_out  output  1  miso output enable; high only while selected
mem_addr_out  output  ADDR_WIDTH  memory byte address
mem_rd_out  output  1  one-cycle read strobe
mem_rdata_in  input  8  read data, valid exactly one clk after mem_rd_out
mem_wr_out  output  1  one-cycle write strobe
mem_wdata_out  output  8  write data, valid with mem_wr_out
busy_out  output  1  high while a transaction is in progress (cs low after sync)
cmd_err_out  output  1  one-cycle pulse on an unsupported command byte

Behaviour:
- Reset values: miso_out=0, miso_oe_out=0, mem_addr_out=0, mem_rd_out=0, mem_wr_out=0, mem_wdata_out=0, busy_out=0, cmd_err_out=0, state=IDLE, all counters 0.
- Input handling: sclk, cs_n and mosi pass through SYNC_STAGES flops. Edges are detected on synced sclk. The rise event samples mosi; the fall event shifts miso.
- States: IDLE, CMD, ADDR, READ_DATA, WRITE_DATA, IGNORE. bit_cnt (3b) counts sampled bits; byte_cnt (2b) counts address bytes.
- IDLE: on synced cs_n falling, go to CMD, clear counters, set busy_out=1 and miso_oe_out=1, miso_out=0.
- CMD: after 8 rises:
  - 0x03 -> ADDR, read mode
  - 0x02 -> ADDR, write mode
  - any other value -> IGNORE, with cmd_err_out pulsed one cycle
- ADDR: shifts in 24 bits MSB first; bits [ADDR_WIDTH-1:0] are kept.
  - On the 24th rise in read mode: drive mem_addr_out and pulse mem_rd_out the same cycle, load mem_rdata_in into tx_shift the next cycle, enter READ_DATA.
  - On the 24th rise in write mode: enter WRITE_DATA.
- READ_DATA:
  - miso_out=tx_shift[7] is updated on each fall event; the first fall after the last address bit presents data bit 7.
  - On the 8th rise of a byte: address+1 (wraps modulo 2^ADDR_WIDTH, 0xFFFF->0x0000), prefetch via mem_rd_out, reload tx_shift so bit 7 appears on the next fall.
  - Reads continue until cs_n rises.
- WRITE_DATA: on the 8th rise of each byte, pulse mem_wr_out for one cycle with mem_addr_out=current address and mem_wdata_out=assembled byte, then address+1 (same wrap). Writes continue until cs_n rises.
- IGNORE: no memory strobes, miso_out=0, until cs_n rises.
- cs_n rising (synced), any state: return to IDLE next cycle with busy_out=0, miso_oe_out=0, miso_out=0. A partially received byte is discarded and no write is issued. An access already strobed is not revoked.
- Simultaneous cs_n rise and 8th-bit rise in the same cycle: the byte completes, so the write or prefetch strobe is issued, then the block goes IDLE.
- Asynchronous reset mid-transaction: all state clears immediately. The controller must re-select before the next transaction is recognised.
- mem_rd_out and mem_wr_out are never high in the same cycle. Each strobe is at most one cycle per byte.

Test Plan:
- Reset: hold reset_n_in=0 with cs_n_in=0 and toggling sclk -> all outputs 0, no strobes. Release -> still IDLE until the next cs_n_in falling edge.
- Single read: memory[0x001E]=0xA5, [0x001F]=0x3C. Send 03 00 00 1E, clock 16 data bits -> mem_rd_out pulses at 0x001E then 0x001F, miso returns 0xA5 then 0x3C, busy_out falls 2-3 clk after cs_n_in rises.
- Write burst: send 02 00 12 34 AA 55 -> mem_wr_out pulses twice (0x1234/0xAA, 0x1235/0x55), mem_rd_out never asserted.
- Wrap: read 03 00 FF FF for 2 bytes -> accesses at 0xFFFF then 0x0000. Upper address byte 0x7F yields identical addresses.
- Bad command: send 0x9F then 24 bits -> cmd_err_out pulses once after the 8th bit, no mem strobes, miso_out=0.
- Abort: write 02 00 00 10 AB, then raise cs_n_in after 5 bits of the second data byte -> exactly one write (0x0010/0xAB). A following read 03 00 00 10 decodes normally.

Source files
------------

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target for the 0x03 READ / 0x02 WRITE command set with 24-bit addressing.
// All SPI pins are oversampled in clk_in and turned into single-cycle byte memory accesses.
module spi_mem_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  sclk_in,
    input  logic                  cs_n_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_rd_out,
    input  logic [7:0]            mem_rdata_in,
    output logic                  mem_wr_out,
    output logic [7:0]            mem_wdata_out,
    output logic                  busy_out,
    output logic                  cmd_err_out
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StReadData,
        StWriteData,
        StIgnore
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic                   read_mode_q, read_mode_d;
    logic [7:0]             rx_q, rx_d, rx_byte;
    logic [7:0]             tx_q, tx_d, tx_src;
    logic                   rd_dly_q;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_shift;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;
    logic                   cmd_err_q, cmd_err_d;

    // Synchronisers reset to 0 so a cs_n held low through reset never looks like a select.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign sclk_fall  = ~sclk_s & sclk_prev;
    assign cs_fall    = ~cs_s & cs_prev;
    assign cs_rise    = cs_s & ~cs_prev;
    assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte    = {rx_q[6:0], mosi_s};
    assign addr_shift = ADDR_WIDTH'({addr_q, mosi_s});
    // Read data lands one cycle after the strobe; a fall in that same cycle must see it directly.
    assign tx_src     = rd_dly_q ? mem_rdata_in : tx_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            read_mode_q <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_dly_q    <= 1'b0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            read_mode_q <= read_mode_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rd_dly_q    <= mem_rd_q;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        read_mode_d = read_mode_q;
        rx_d        = rx_q;
        tx_d        = tx_src;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        busy_d      = busy_q;
        cmd_err_d   = 1'b0;

        if (state_q != StIdle && sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = rx_byte;
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StCmd;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                    miso_oe_d  = 1'b1;
                    miso_d     = 1'b0;
                end
            end
            StCmd: begin
                if (byte_done) begin
                    byte_cnt_d = '0;
                    if (rx_byte == 8'h03) begin
                        state_d     = StAddr;
                        read_mode_d = 1'b1;
                    end else if (rx_byte == 8'h02) begin
                        state_d     = StAddr;
                        read_mode_d = 1'b0;
                    end else begin
                        state_d   = StIgnore;
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (sclk_rise) begin
                    addr_d = addr_shift;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            if (read_mode_q) begin
                                state_d    = StReadData;
                                mem_addr_d = addr_shift;
                                mem_rd_d   = 1'b1;
                            end else begin
                                state_d = StWriteData;
                            end
                        end
                    end
                end
            end
            StReadData: begin
                if (sclk_fall) begin
                    miso_d = tx_src[7];
                    tx_d   = {tx_src[6:0], 1'b0};
                end
                if (byte_done) begin
                    addr_d     = addr_q + AddrOne;
                    mem_addr_d = addr_q + AddrOne;
                    mem_rd_d   = 1'b1;
                end
            end
            StWriteData: begin
                if (byte_done) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = rx_byte;
                    mem_wr_d    = 1'b1;
                    addr_d      = addr_q + AddrOne;
                end
            end
            StIgnore: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Deselect wins over everything except a byte strobe already decided this cycle.
        if (state_q != StIdle && cs_rise) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
        end
    end

    assign miso_out      = miso_q;
    assign miso_oe_out   = miso_oe_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_rd_out    = mem_rd_q;
    assign mem_wr_out    = mem_wr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign busy_out      = busy_q;
    assign cmd_err_out   = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: acts as SPI controller plus byte memory, checks against a
// transaction-level model (expected memory image and expected access lists).
module tb_spi_mem_responder;

    localparam int HALF = 5;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        sclk_in = 1'b0;
    logic        cs_n_in = 1'b0;
    logic        mosi_in = 1'b0;
    logic        miso_out, miso_oe_out;
    logic [15:0] mem_addr_out;
    logic        mem_rd_out, mem_wr_out;
    logic [7:0]  mem_rdata_in = 8'h00;
    logic [7:0]  mem_wdata_out;
    logic        busy_out, cmd_err_out;

    int checks = 0;
    int errors = 0;

    spi_mem_responder #(
        .SYNC_STAGES(2),
        .ADDR_WIDTH (16)
    ) dut (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .sclk_in      (sclk_in),
        .cs_n_in      (cs_n_in),
        .mosi_in      (mosi_in),
        .miso_out     (miso_out),
        .miso_oe_out  (miso_oe_out),
        .mem_addr_out (mem_addr_out),
        .mem_rd_out   (mem_rd_out),
        .mem_rdata_in (mem_rdata_in),
        .mem_wr_out   (mem_wr_out),
        .mem_wdata_out(mem_wdata_out),
        .busy_out     (busy_out),
        .cmd_err_out  (cmd_err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h001E) return 8'hA5;
        if (a == 16'h001F) return 8'h3C;
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
    endfunction

    // Environment memory: unwritten locations read their initial pattern.
    logic [7:0] mem     [0:65535];
    logic       written [0:65535];
    always @(posedge clk_in) begin
        if (mem_wr_out) begin
            mem[mem_addr_out]     <= mem_wdata_out;
            written[mem_addr_out] <= 1'b1;
        end
        if (mem_rd_out)
            mem_rdata_in <= (written[mem_addr_out] === 1'b1) ? mem[mem_addr_out]
                                                             : init_val(mem_addr_out);
    end

    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    int          err_pulses = 0;
    bit          both_seen = 0;
    bit          reset_bad = 0;
    always @(negedge clk_in) begin
        if (mem_rd_out) rd_log.push_back(mem_addr_out);
        if (mem_wr_out) begin
            wr_addr_log.push_back(mem_addr_out);
            wr_data_log.push_back(mem_wdata_out);
        end
        if (mem_rd_out && mem_wr_out) both_seen = 1;
        if (cmd_err_out) err_pulses++;
        if (!reset_n_in && ({miso_out, miso_oe_out, mem_addr_out, mem_rd_out, mem_wr_out,
                              mem_wdata_out, busy_out, cmd_err_out} !== '0))
            reset_bad = 1;
    end

    // Reference model state
    logic [7:0] ref_mem [0:65535];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    function automatic logic [15:0] wrap_addr(input logic [23:0] a, input int k);
        return 16'((int'(a[15:0]) + k) % 65536);
    endfunction

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = tx[7-i];
            repeat (HALF) @(negedge clk_in);
            rx = {rx[6:0], miso_out};
            sclk_in = 1'b1;
            repeat (HALF) @(negedge clk_in);
            sclk_in = 1'b0;
        end
    endtask

    task automatic spi_begin(output logic sel_ok);
        cs_n_in = 1'b0;
        repeat (HALF) @(negedge clk_in);
        sel_ok = busy_out && miso_oe_out;
    endtask

    task automatic spi_end(output int lat);
        repeat (HALF) @(negedge clk_in);
        cs_n_in = 1'b1;
        lat = 0;
        while (busy_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        repeat (2 * HALF) @(negedge clk_in);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        spi_byte(cmd, 8, d);
        spi_byte(a[23:16], 8, d);
        spi_byte(a[15:8], 8, d);
        spi_byte(a[7:0], 8, d);
    endtask

    task automatic do_read(input logic [23:0] a, input int n, output int lat, output logic sel);
        logic [7:0] d;
        rx_q.delete();
        spi_begin(sel);
        send_header(8'h03, a);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, 8, d);
            rx_q.push_back(d);
        end
        spi_end(lat);
    endtask

    task automatic do_write(input logic [23:0] a, output int lat);
        logic [7:0] d;
        logic       sel;
        spi_begin(sel);
        send_header(8'h02, a);
        foreach (tx_q[k]) spi_byte(tx_q[k], 8, d);
        spi_end(lat);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int r0, w0, e0;
        reset_n_in = 1'b0;
        cs_n_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sclk_in = ~sclk_in;
            mosi_in = i[0];
            repeat (2) @(negedge clk_in);
        end
        sclk_in = 1'b0;
        checks++;
        if (reset_bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: nonzero output seen during reset, required all zero");
        end
        r0 = rd_log.size(); w0 = wr_addr_log.size(); e0 = err_pulses;
        reset_n_in = 1'b1;
        // cs_n still low: no transaction may start without a fresh select
        send_header(8'h03, 24'h000000);
        spi_byte(8'h00, 8, d);
        checks++;
        if ({busy_out, miso_oe_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/oe = %b, required 00", {busy_out, miso_oe_out});
        end
        checks++;
        if ((rd_log.size() - r0) + (wr_addr_log.size() - w0) + (err_pulses - e0) != 0) begin
            errors++;
            $display("FAIL reset_no_strobes: %0d strobes, required 0",
                     (rd_log.size() - r0) + (wr_addr_log.size() - w0) + (err_pulses - e0));
        end
        cs_n_in = 1'b1;
        repeat (2 * HALF) @(negedge clk_in);
    endtask

    task automatic test_single_read;
        int r0, lat;
        logic sel;
        r0 = rd_log.size();
        do_read(24'h00001E, 2, lat, sel);
        checks++;
        if (sel !== 1'b1) begin
            errors++;
            $display("FAIL read_select: busy&oe = %b, required 1", sel);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_q[k] !== ref_mem[wrap_addr(24'h1E, k)]) begin
                errors++;
                $display("FAIL read_data[%0d]: got %h, required %h", k, rx_q[k],
                         ref_mem[wrap_addr(24'h1E, k)]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_log.size() <= r0 + k || rd_log[r0+k] !== wrap_addr(24'h1E, k)) begin
                errors++;
                $display("FAIL read_addr[%0d]: got %0d strobes, required addr %h", k,
                         rd_log.size() - r0, wrap_addr(24'h1E, k));
            end
        end
        checks++;
        if (lat < 2 || lat > 3) begin
            errors++;
            $display("FAIL busy_release: got %0d clk, required 2..3", lat);
        end
    endtask

    task automatic test_write_burst;
        int r0, w0, lat;
        logic sel;
        r0 = rd_log.size(); w0 = wr_addr_log.size();
        tx_q = '{8'hAA, 8'h55};
        do_write(24'h001234, lat);
        foreach (tx_q[k]) ref_mem[wrap_addr(24'h1234, k)] = tx_q[k];
        checks++;
        if (wr_addr_log.size() - w0 != 2 || rd_log.size() != r0) begin
            errors++;
            $display("FAIL write_counts: got %0d writes %0d reads, required 2 and 0",
                     wr_addr_log.size() - w0, rd_log.size() - r0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({wr_addr_log[w0+k], wr_data_log[w0+k]} !==
                    {wrap_addr(24'h1234, k), tx_q[k]}) begin
                    errors++;
                    $display("FAIL write_access[%0d]: got %h/%h, required %h/%h", k,
                             wr_addr_log[w0+k], wr_data_log[w0+k], wrap_addr(24'h1234, k), tx_q[k]);
                end
            end
        end
        do_read(24'h001234, 2, lat, sel);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx_q[k] !== ref_mem[wrap_addr(24'h1234, k)]) begin
                errors++;
                $display("FAIL write_readback[%0d]: got %h, required %h", k, rx_q[k],
                         ref_mem[wrap_addr(24'h1234, k)]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [23:0] starts [2];
        int r0, lat;
        logic sel;
        starts[0] = 24'h00FFFF;
        starts[1] = 24'h7FFFFF;
        for (int s = 0; s < 2; s++) begin
            r0 = rd_log.size();
            do_read(starts[s], 2, lat, sel);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rd_log.size() <= r0 + k || rd_log[r0+k] !== wrap_addr(starts[s], k)) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d][%0d]: got %0d strobes, required addr %h", s, k,
                             rd_log.size() - r0, wrap_addr(starts[s], k));
                end
                checks++;
                if (rx_q[k] !== ref_mem[wrap_addr(starts[s], k)]) begin
                    errors++;
                    $display("FAIL wrap_data[%0d][%0d]: got %h, required %h", s, k, rx_q[k],
                             ref_mem[wrap_addr(starts[s], k)]);
                end
            end
        end
    endtask

    task automatic test_bad_cmd;
        int r0, w0, e0, lat;
        logic [7:0] d;
        logic [7:0] acc;
        logic sel;
        r0 = rd_log.size(); w0 = wr_addr_log.size(); e0 = err_pulses;
        spi_begin(sel);
        spi_byte(8'h9F, 8, d);
        checks++;
        if (err_pulses - e0 != 1) begin
            errors++;
            $display("FAIL bad_cmd_pulse: got %0d pulses after 8th bit, required 1",
                     err_pulses - e0);
        end
        acc = 8'h00;
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'($urandom), 8, d);
            acc = acc | d;
        end
        spi_end(lat);
        checks++;
        if (acc !== 8'h00) begin
            errors++;
            $display("FAIL bad_cmd_miso: got %h, required 00", acc);
        end
        checks++;
        if ((err_pulses - e0 != 1) || (rd_log.size() != r0) || (wr_addr_log.size() != w0)) begin
            errors++;
            $display("FAIL bad_cmd_strobes: got %0d err %0d rd %0d wr, required 1 0 0",
                     err_pulses - e0, rd_log.size() - r0, wr_addr_log.size() - w0);
        end
    endtask

    task automatic test_abort;
        int r0, w0, lat;
        logic [7:0] d;
        logic sel;
        w0 = wr_addr_log.size();
        spi_begin(sel);
        send_header(8'h02, 24'h000010);
        spi_byte(8'hAB, 8, d);
        spi_byte(8'($urandom), 5, d);
        spi_end(lat);
        ref_mem[16'h0010] = 8'hAB;
        checks++;
        if (wr_addr_log.size() - w0 != 1 ||
            {wr_addr_log[w0], wr_data_log[w0]} !== {16'h0010, 8'hAB}) begin
            errors++;
            $display("FAIL abort_write: got %0d writes, required exactly 0010/ab",
                     wr_addr_log.size() - w0);
        end
        r0 = rd_log.size();
        do_read(24'h000010, 1, lat, sel);
        checks++;
        if (rx_q[0] !== ref_mem[16'h0010]) begin
            errors++;
            $display("FAIL abort_readback: got %h, required %h", rx_q[0], ref_mem[16'h0010]);
        end
        checks++;
        if (rd_log.size() <= r0 || rd_log[r0] !== 16'h0010) begin
            errors++;
            $display("FAIL abort_read_addr: got %0d strobes, required first at 0010",
                     rd_log.size() - r0);
        end
    endtask

    task automatic test_random;
        logic [23:0] a;
        int n, r0, w0, lat;
        bit ok;
        logic sel;
        for (int t = 0; t < 8; t++) begin
            a = 24'($urandom);
            if (t[1]) a[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            r0 = rd_log.size(); w0 = wr_addr_log.size();
            if ($urandom_range(0, 1) == 1) begin
                tx_q.delete();
                for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
                do_write(a, lat);
                for (int k = 0; k < n; k++) ref_mem[wrap_addr(a, k)] = tx_q[k];
                ok = (wr_addr_log.size() - w0 == n) && (rd_log.size() == r0);
                for (int k = 0; k < n && ok; k++)
                    ok = {wr_addr_log[w0+k], wr_data_log[w0+k]} === {wrap_addr(a, k), tx_q[k]};
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: addr %h len %0d, got %0d writes", t, a, n,
                             wr_addr_log.size() - w0);
                end
            end else begin
                do_read(a, n, lat, sel);
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (rx_q[k] !== ref_mem[wrap_addr(a, k)]) begin
                        errors++;
                        $display("FAIL rand_read[%0d][%0d]: got %h, required %h", t, k, rx_q[k],
                                 ref_mem[wrap_addr(a, k)]);
                    end
                end
                ok = (rd_log.size() - r0 >= n) && (wr_addr_log.size() == w0);
                for (int k = 0; k < n && ok; k++) ok = rd_log[r0+k] === wrap_addr(a, k);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_read_addr[%0d]: addr %h len %0d, got %0d reads", t, a, n,
                             rd_log.size() - r0);
                end
            end
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("FAIL strobe_exclusive: rd and wr seen together, required never");
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
        test_reset();
        test_single_read();
        test_write_burst();
        test_wrap();
        test_bad_cmd();
        test_abort();
        test_random();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
